// File: rtl/flush_ctrl.sv
// Pipeline flush/redirect controller: arbitrates mispredicts against per-stage exceptions,
// holds a per-stage kill mask, drains memory before trap entry, then emits one redirect pulse.
module flush_ctrl #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_STAGES   = 5,
    parameter int BR_STAGE     = 2,
    parameter int CAUSE_W      = 8,
    parameter int FLUSH_CYCLES = 1,
    parameter int COUNT_W      = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             br_valid,
    input  logic [DATA_WIDTH-1:0]            br_pred_pc,
    input  logic [DATA_WIDTH-1:0]            br_actual_pc,
    input  logic [NUM_STAGES-1:0]            exc_valid,
    input  logic [NUM_STAGES*CAUSE_W-1:0]    exc_cause,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0] exc_pc,
    input  logic [DATA_WIDTH-1:0]            trap_vector,
    input  logic                             mem_busy,
    output logic [NUM_STAGES-1:0]            flush,
    output logic                             stall,
    output logic                             redirect_valid,
    output logic [DATA_WIDTH-1:0]            redirect_pc,
    output logic                             trap_valid,
    output logic [CAUSE_W-1:0]               trap_cause,
    output logic [DATA_WIDTH-1:0]            trap_epc,
    output logic [COUNT_W-1:0]               mispredict_cnt,
    output logic [COUNT_W-1:0]               exception_cnt
);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [NUM_STAGES-1:0] BR_MASK  = NUM_STAGES'((64'd1 << BR_STAGE) - 64'd1);
    localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_REDIR = 2'd3;

    logic [1:0]            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [NUM_STAGES-1:0] mask, mask_d, exc_mask;
    logic [DATA_WIDTH-1:0] target;
    logic                  is_exc;
    logic [IDX_W-1:0]      exc_idx;
    logic                  mispredict, exc_any, take_exc, accept;

    // Highest set index is the oldest faulting instruction; later iterations override.
    always_comb begin
        exc_idx  = '0;
        exc_mask = '0;
        for (int s = 0; s < NUM_STAGES; s++)
            if (exc_valid[s]) exc_idx = IDX_W'(s);
        for (int s = 0; s < NUM_STAGES; s++)
            exc_mask[s] = (IDX_W'(s) <= exc_idx);
    end

    assign mispredict = br_valid && (br_pred_pc != br_actual_pc);
    assign exc_any    = |exc_valid;
    // An exception younger than the branch is killed by the mispredict.
    assign take_exc   = exc_any && (!mispredict || (int'(exc_idx) >= BR_STAGE));
    assign accept     = (state == S_IDLE) && enable && (mispredict || exc_any);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        mask_d  = mask;
        case (state)
            S_IDLE: if (accept) begin
                state_d = S_FLUSH;
                cnt_d   = CNT_INIT;
                mask_d  = take_exc ? exc_mask : BR_MASK;
            end
            S_FLUSH: begin
                if (cnt == '0) state_d = (is_exc && mem_busy) ? S_DRAIN : S_REDIR;
                else           cnt_d   = cnt - 1'b1;
            end
            S_DRAIN: if (!mem_busy) state_d = S_REDIR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            mask           <= '0;
            target         <= '0;
            is_exc         <= 1'b0;
            flush          <= '0;
            stall          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            trap_valid     <= 1'b0;
            trap_cause     <= '0;
            trap_epc       <= '0;
            mispredict_cnt <= '0;
            exception_cnt  <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            mask           <= mask_d;
            flush          <= (state_d == S_FLUSH || state_d == S_DRAIN) ? mask_d : '0;
            stall          <= (state_d != S_IDLE);
            redirect_valid <= (state_d == S_REDIR);
            trap_valid     <= (state_d == S_REDIR) && is_exc;
            if (state_d == S_REDIR) redirect_pc <= target;
            if (accept) begin
                is_exc <= take_exc;
                if (take_exc) begin
                    target        <= trap_vector;
                    trap_cause    <= exc_cause[exc_idx*CAUSE_W +: CAUSE_W];
                    trap_epc      <= exc_pc[exc_idx*DATA_WIDTH +: DATA_WIDTH];
                    exception_cnt <= exception_cnt + 1'b1;
                end else begin
                    target         <= br_actual_pc;
                    mispredict_cnt <= mispredict_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_flush_ctrl.sv
// Bench for flush_ctrl: two instances (FLUSH_CYCLES=1/COUNT_W=4 and FLUSH_CYCLES=3) share stimulus;
// redirects are checked by a scoreboard monitor, flush/stall/counters by directed checks.
module tb_flush_ctrl;
    logic         clk, rst, enable, br_valid, mem_busy;
    logic [63:0]  br_pred_pc, br_actual_pc, trap_vector;
    logic [4:0]   exc_valid;
    logic [39:0]  exc_cause;
    logic [319:0] exc_pc;

    logic [4:0]  a_fl, b_fl;
    logic        a_st, b_st, a_rv, b_rv, a_tv, b_tv;
    logic [63:0] a_rpc, b_rpc, a_epc, b_epc;
    logic [7:0]  a_cause, b_cause;
    logic [3:0]  a_mcnt, a_ecnt;
    logic [31:0] b_mcnt, b_ecnt;

    typedef struct {
        logic [63:0] pc;
        logic        trap;
        logic [7:0]  cause;
        logic [63:0] epc;
    } exp_t;
    exp_t qa[$], qb[$];

    int tests = 0, fails = 0;

    flush_ctrl #(.COUNT_W(4)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .br_valid(br_valid), .br_pred_pc(br_pred_pc),
        .br_actual_pc(br_actual_pc), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .trap_vector(trap_vector), .mem_busy(mem_busy), .flush(a_fl), .stall(a_st),
        .redirect_valid(a_rv), .redirect_pc(a_rpc), .trap_valid(a_tv), .trap_cause(a_cause),
        .trap_epc(a_epc), .mispredict_cnt(a_mcnt), .exception_cnt(a_ecnt));

    flush_ctrl #(.FLUSH_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .br_valid(br_valid), .br_pred_pc(br_pred_pc),
        .br_actual_pc(br_actual_pc), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .trap_vector(trap_vector), .mem_busy(mem_busy), .flush(b_fl), .stall(b_st),
        .redirect_valid(b_rv), .redirect_pc(b_rpc), .trap_valid(b_tv), .trap_cause(b_cause),
        .trap_epc(b_epc), .mispredict_cnt(b_mcnt), .exception_cnt(b_ecnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_ev();
        br_valid = 1'b0; br_pred_pc = '0; br_actual_pc = '0;
        exc_valid = '0; exc_cause = '0; exc_pc = '0;
    endtask

    function automatic exp_t mk(input logic [63:0] pc, input logic trap,
                                input logic [7:0] c, input logic [63:0] e);
        exp_t x;
        x.pc = pc; x.trap = trap; x.cause = c; x.epc = e;
        return x;
    endfunction

    task automatic misp(input logic [63:0] p, input logic [63:0] a);
        br_valid = 1'b1; br_pred_pc = p; br_actual_pc = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst = 1'b1; enable = 1'b1; mem_busy = 1'b0; trap_vector = 64'h8000_0000;
        clr_ev();

        // Scoreboard monitor: every redirect pulse must match the oldest pending expectation.
        fork
            forever begin
                @(negedge clk);
                if (!rst && a_rv) begin
                    if (qa.size() == 0) chk("unexpected_redirect_a", a_rpc, 64'hDEAD);
                    else begin
                        e = qa.pop_front();
                        chk("redir_pc_a", a_rpc, e.pc);
                        chk("trap_valid_a", {63'd0, a_tv}, {63'd0, e.trap});
                        if (e.trap) begin
                            chk("trap_cause_a", {56'd0, a_cause}, {56'd0, e.cause});
                            chk("trap_epc_a", a_epc, e.epc);
                        end
                    end
                end
                if (!rst && b_rv) begin
                    if (qb.size() == 0) chk("unexpected_redirect_b", b_rpc, 64'hDEAD);
                    else begin
                        e = qb.pop_front();
                        chk("redir_pc_b", b_rpc, e.pc);
                        chk("trap_valid_b", {63'd0, b_tv}, {63'd0, e.trap});
                    end
                end
            end
        join_none

        idle(2);
        chk("reset_flush", {59'd0, a_fl}, 0);
        chk("reset_stall", {63'd0, a_st}, 0);
        chk("reset_redirect", {63'd0, a_rv}, 0);
        chk("reset_mcnt", {60'd0, a_mcnt}, 0);
        chk("reset_ecnt", {60'd0, a_ecnt}, 0);
        rst = 1'b0;
        idle(2);

        // Correct prediction: nothing happens
        misp(64'h1000, 64'h1000);
        tick(); clr_ev();
        chk("correct_pred_flush", {59'd0, a_fl}, 0);
        chk("correct_pred_stall", {63'd0, a_st}, 0);
        idle(2);
        chk("correct_pred_cnt", {60'd0, a_mcnt}, 0);
        idle(3);

        // Plain mispredict
        misp(64'h1004, 64'h2000);
        qa.push_back(mk(64'h2000, 0, 0, 0)); qb.push_back(mk(64'h2000, 0, 0, 0));
        tick(); clr_ev();
        chk("misp_flush", {59'd0, a_fl}, 64'h3);
        chk("misp_stall", {63'd0, a_st}, 1);
        tick();
        chk("misp_redirect_valid", {63'd0, a_rv}, 1);
        chk("misp_cnt", {60'd0, a_mcnt}, 1);
        idle(5);

        // Exception at stage 3 with memory drain (mem_busy high 3 cycles)
        exc_valid = 5'b01010;
        exc_pc[3*64 +: 64] = 64'h80; exc_cause[3*8 +: 8] = 8'h5;
        exc_pc[1*64 +: 64] = 64'h40; exc_cause[1*8 +: 8] = 8'h9;
        mem_busy = 1'b1;
        qa.push_back(mk(64'h8000_0000, 1, 8'h5, 64'h80));
        qb.push_back(mk(64'h8000_0000, 1, 8'h5, 64'h80));
        tick(); clr_ev();
        chk("exc_flush_t1", {59'd0, a_fl}, 64'hF);
        tick();
        chk("exc_flush_drain_t2", {59'd0, a_fl}, 64'hF);
        chk("exc_stall_drain", {63'd0, a_st}, 1);
        tick();
        chk("exc_flush_drain_t3", {59'd0, a_fl}, 64'hF);
        mem_busy = 1'b0;
        tick();
        chk("exc_redirect_flush", {59'd0, a_fl}, 0);
        chk("exc_redirect_valid", {63'd0, a_rv}, 1);
        chk("exc_cnt", {60'd0, a_ecnt}, 1);
        idle(5);

        // Mispredict + younger exception: mispredict wins
        misp(64'h3000, 64'h3100); exc_valid = 5'b00010;
        exc_pc[1*64 +: 64] = 64'h44; exc_cause[1*8 +: 8] = 8'h2;
        qa.push_back(mk(64'h3100, 0, 0, 0)); qb.push_back(mk(64'h3100, 0, 0, 0));
        tick(); clr_ev();
        chk("misp_vs_young_flush", {59'd0, a_fl}, 64'h3);
        idle(5);
        chk("misp_vs_young_mcnt", {60'd0, a_mcnt}, 2);
        chk("misp_vs_young_ecnt", {60'd0, a_ecnt}, 1);

        // Mispredict + older exception: exception wins
        misp(64'h3000, 64'h3200); exc_valid = 5'b01000;
        exc_pc[3*64 +: 64] = 64'h1234; exc_cause[3*8 +: 8] = 8'h7;
        qa.push_back(mk(64'h8000_0000, 1, 8'h7, 64'h1234));
        qb.push_back(mk(64'h8000_0000, 1, 8'h7, 64'h1234));
        tick(); clr_ev();
        chk("exc_vs_misp_flush", {59'd0, a_fl}, 64'hF);
        idle(5);
        chk("exc_vs_misp_mcnt", {60'd0, a_mcnt}, 2);
        chk("exc_vs_misp_ecnt", {60'd0, a_ecnt}, 2);

        // enable low: event ignored
        enable = 1'b0; misp(64'h10, 64'h20);
        tick(); clr_ev(); enable = 1'b1;
        chk("disabled_flush", {59'd0, a_fl}, 0);
        chk("disabled_mcnt", {60'd0, a_mcnt}, 2);
        idle(5);

        // FLUSH_CYCLES=3 instance: mask held exactly 3 cycles, redirect on the 4th
        misp(64'h500, 64'h600);
        qa.push_back(mk(64'h600, 0, 0, 0)); qb.push_back(mk(64'h600, 0, 0, 0));
        tick(); clr_ev();
        chk("fc3_flush_1", {59'd0, b_fl}, 64'h3);
        tick();
        chk("fc3_flush_2", {59'd0, b_fl}, 64'h3);
        tick();
        chk("fc3_flush_3", {59'd0, b_fl}, 64'h3);
        chk("fc3_no_early_redirect", {63'd0, b_rv}, 0);
        tick();
        chk("fc3_flush_4", {59'd0, b_fl}, 0);
        chk("fc3_redirect", {63'd0, b_rv}, 1);
        idle(4);

        // Back-to-back on the short instance: second event in the IDLE cycle after REDIRECT
        misp(64'h10, 64'h7000);
        qa.push_back(mk(64'h7000, 0, 0, 0)); qb.push_back(mk(64'h7000, 0, 0, 0));
        tick(); clr_ev();
        tick();
        chk("b2b_first_redirect", {63'd0, a_rv}, 1);
        tick();
        exc_valid = 5'b10000; exc_pc[4*64 +: 64] = 64'h9000; exc_cause[4*8 +: 8] = 8'h3;
        qa.push_back(mk(64'h8000_0000, 1, 8'h3, 64'h9000));
        tick(); clr_ev();
        chk("b2b_second_flush", {59'd0, a_fl}, 64'h1F);
        tick();
        chk("b2b_second_redirect", {63'd0, a_rv}, 1);
        idle(6);

        // Reset during DRAIN: outputs clear, no redirect ever
        exc_valid = 5'b00100; exc_pc[2*64 +: 64] = 64'hAA; mem_busy = 1'b1;
        tick(); clr_ev();
        tick();
        chk("pre_reset_in_drain", {59'd0, a_fl}, 64'h7);
        rst = 1'b1; #1;
        chk("rst_drain_flush", {59'd0, a_fl}, 0);
        chk("rst_drain_stall", {63'd0, a_st}, 0);
        chk("rst_drain_ecnt", {60'd0, a_ecnt}, 0);
        tick();
        rst = 1'b0; mem_busy = 1'b0;
        idle(6);
        chk("rst_drain_no_redirect", {63'd0, a_st}, 0);

        // 16 mispredicts wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            misp(64'h100, 64'h200 + 64'(i));
            qa.push_back(mk(64'h200 + 64'(i), 0, 0, 0));
            qb.push_back(mk(64'h200 + 64'(i), 0, 0, 0));
            tick(); clr_ev();
            idle(6);
            if (i == 14) chk("wrap_cnt_15", {60'd0, a_mcnt}, 15);
        end
        chk("wrap_cnt_0", {60'd0, a_mcnt}, 0);
        chk("wrap_cnt_b", {32'd0, b_mcnt}, 16);

        idle(3);
        chk("scoreboard_a_empty", 64'(qa.size()), 0);
        chk("scoreboard_b_empty", 64'(qb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
